conv_ctrl: RTL and testbench
============================

# conv_ctrl

Sequencer for the `conv_layer` datapath. On `start_i` it sweeps a K×K window across an IMG_W×IMG_H single-channel feature map, stride 1, no padding. For each output pixel it issues one input-buffer read per kernel tap and drives the accumulator clear/enable and tap index. It then presents the finished pixel on a valid/ready output handshake and pulses `done_o` after the last pixel. It sits between the top-level control and `conv_layer` and the input and output feature buffers.

## Interface
- IMG_W, default 8: input map width in pixels.
- IMG_H, default 8: input map height in pixels.
- K, default 3: kernel size (K×K taps); K ≤ IMG_W, K ≤ IMG_H.
- ADDR_W, default 6: address width; 2^ADDR_W ≥ IMG_W·IMG_H.
- TAP_W, default 4: tap index width; 2^TAP_W ≥ K·K.
- Derived: OUT_W = IMG_W−K+1, OUT_H = IMG_H−K+1.

Ports:
- clk_i, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start_i, in, 1: start request; sampled only in IDLE.
- busy_o, out, 1: high in every state except IDLE.
- rd_en_o, out, 1: input-buffer read strobe.
- rd_addr_o, out, ADDR_W: input-buffer read address.
- acc_clr_o, out, 1: accumulator clear, aligned with the first tap's read data.
- acc_en_o, out, 1: accumulate enable, aligned with read data (rd_en_o delayed 1 cycle).
- tap_o, out, TAP_W: weight index ky·K+kx, aligned with acc_en_o.
- out_valid_o, out, 1: accumulated pixel ready for write-back.
- out_ready_i, in, 1: downstream accepts the pixel.
- out_addr_o, out, ADDR_W: output index oy·OUT_W+ox.
- done_o, out, 1: one-cycle pulse after the last pixel is accepted.

## Operation
- States are IDLE, FETCH, DRAIN, WRITE and DONE.
- Counters:
  - ox and oy count output position.
  - kx and ky count kernel position.
  - All are zero in IDLE.
- IDLE: if start_i = 1, clear all counters and go to FETCH. Otherwise stay.
- FETCH:
  - rd_en_o = 1; rd_addr_o = (oy+ky)·IMG_W + (ox+kx).
  - kx increments each cycle. When it wraps at K−1, it goes to 0 and ky increments.
  - After the tap (K−1, K−1), go to DRAIN and reset kx and ky to 0.
- DRAIN: a single cycle in which the last tap's data is accumulated (acc_en_o = 1). Then go to WRITE.
- WRITE:
  - out_valid_o = 1; out_addr_o = oy·OUT_W+ox, held stable until out_valid_o & out_ready_i.
  - On the handshake:
    - If ox = OUT_W−1 and oy = OUT_H−1, go to DONE.
    - Otherwise advance ox (wrapping to 0 and incrementing oy) and go to FETCH.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- Accumulator control is registered copies of the FETCH controls:
  - acc_en_o(t) = rd_en_o(t−1).
  - acc_clr_o(t) = 1 when the read in cycle t−1 was tap (0, 0).
  - tap_o(t) = ky·K+kx of cycle t−1.
- start_i is ignored in every state other than IDLE, including DONE.
- Address arithmetic is unsigned and fits ADDR_W by the parameter constraint; no wrap-around is possible.

## Timing
- Reset value of every output is 0: busy_o, rd_en_o, rd_addr_o, acc_clr_o, acc_en_o, tap_o, out_valid_o, out_addr_o and done_o. The state is IDLE and all counters are 0.
- Reset asserted mid-operation aborts immediately, with no done_o and no further reads.
- Latency from start_i to the first rd_en_o is 1 cycle.
- Cycles per pixel with out_ready_i held high: K·K + 2 (11 for K = 3).
- Start sampled in cycle 0 gives:
  - pixel n (0-based) in WRITE at cycle (n+1)·(K·K+2);
  - done_o at cycle OUT_W·OUT_H·(K·K+2)+1 (397 for defaults).
- Each cycle out_ready_i is low in WRITE adds exactly one cycle. No read is issued while in WRITE.
- out_valid_o never drops without a handshake. out_addr_o is stable while out_valid_o = 1.
- Outputs are registered or decoded from state and counters only. There is no combinational path from out_ready_i to any output except the next-state transition.

## Test plan
- Defaults, out_ready_i = 1, start pulse at cycle 0:
  - cycles 1–9 read addresses 0,1,2,8,9,10,16,17,18;
  - acc_clr_o at cycle 2, acc_en_o at cycles 2–10, tap_o 0..8;
  - out_valid_o at cycle 11 with out_addr_o = 0.
- Full run, defaults: 36 WRITE handshakes with out_addr_o 0..35 in order.
  - The last pixel reads 45,46,47,53,54,55,61,62,63.
  - done_o is high only at cycle 397; busy_o drops at cycle 398.
- Backpressure: out_ready_i low for 5 cycles during pixel 0's WRITE.
  - out_valid_o = 1 and out_addr_o = 0 are held; rd_en_o = 0 throughout.
  - done_o moves to cycle 402.
- start_i pulsed during FETCH, in WRITE, and in the DONE cycle: no restart and no counter disturbance. A start in IDLE afterwards restarts from address 0.
- rst_n low at cycle 50, released at cycle 53:
  - all outputs are 0 within the reset cycle;
  - no done_o appears;
  - a new start reproduces the first-scenario sequence exactly.
- K = 1, IMG_W = IMG_H = 2 configuration:
  - 3 cycles per pixel; reads 0,1,2,3;
  - done_o at cycle 13.

Source files
------------

// File: rtl/conv_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : conv_ctrl_if
// Description : Bus bundle between the convolution sequencer and its
//               neighbours: input-buffer read port, accumulator control for
//               conv_layer, and the output-pixel valid/ready handshake.
//               master = sequencer side, slave = datapath/buffer side.
// Ports       : rd_en_o/rd_addr_o    input-buffer read strobe and address
//               acc_clr_o/acc_en_o   accumulator clear / enable
//               tap_o                weight index aligned with acc_en_o
//               out_valid_o/out_ready_i/out_addr_o  output-pixel handshake
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface conv_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int TAP_W  = 4
);
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              acc_clr_o;
    logic              acc_en_o;
    logic [TAP_W-1:0]  tap_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [ADDR_W-1:0] out_addr_o;

    modport master (
        output rd_en_o, rd_addr_o, acc_clr_o, acc_en_o, tap_o,
        output out_valid_o, out_addr_o,
        input  out_ready_i
    );

    modport slave (
        input  rd_en_o, rd_addr_o, acc_clr_o, acc_en_o, tap_o,
        input  out_valid_o, out_addr_o,
        output out_ready_i
    );
endinterface

`default_nettype wire

// File: rtl/conv_ctrl.sv
//------------------------------------------------------------------------------
// Module      : conv_ctrl
// Description : Sequencer for the conv_layer datapath. Sweeps a KxK window
//               (stride 1, no padding) over an IMG_W x IMG_H map, issuing one
//               input read per tap, driving accumulator clear/enable/tap, then
//               presenting each finished pixel on a valid/ready handshake.
//               done_o pulses for one cycle after the last pixel is accepted.
// Ports       : clk_i    rising-edge clock
//               rst_n    asynchronous active-low reset
//               start_i  start request, honoured only in IDLE
//               busy_o   high whenever not IDLE
//               done_o   one-cycle completion pulse
//               bus      conv_ctrl_if master modport (read / acc / output)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_ctrl #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 6,
    parameter int TAP_W  = 4
) (
    input  wire logic    clk_i,
    input  wire logic    rst_n,
    input  wire logic    start_i,
    output logic         busy_o,
    output logic         done_o,
    conv_ctrl_if.master  bus
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;

    localparam logic [ADDR_W-1:0] c_km1     = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] c_img_w   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] c_out_w   = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0] c_out_wm1 = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] c_out_hm1 = ADDR_W'(OUT_H - 1);
    localparam logic [TAP_W-1:0]  c_k_tap   = TAP_W'(K);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_ox, r_oy, r_kx, r_ky;
    logic [ADDR_W-1:0] w_ox_nxt, w_oy_nxt, w_kx_nxt, w_ky_nxt;

    // Registered accumulator controls: one cycle behind the read they follow
    logic              r_acc_en;
    logic              r_acc_clr;
    logic [TAP_W-1:0]  r_tap;

    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [TAP_W-1:0]  w_tap;
    logic              w_first_tap;
    logic              w_out_valid;
    logic [ADDR_W-1:0] w_out_addr;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ox      <= '0;
            r_oy      <= '0;
            r_kx      <= '0;
            r_ky      <= '0;
            r_acc_en  <= 1'b0;
            r_acc_clr <= 1'b0;
            r_tap     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ox      <= w_ox_nxt;
            r_oy      <= w_oy_nxt;
            r_kx      <= w_kx_nxt;
            r_ky      <= w_ky_nxt;
            r_acc_en  <= w_rd_en;
            r_acc_clr <= w_rd_en & w_first_tap;
            r_tap     <= w_tap;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ox_nxt    = r_ox;
        w_oy_nxt    = r_oy;
        w_kx_nxt    = r_kx;
        w_ky_nxt    = r_ky;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        w_tap       = '0;
        w_first_tap = (r_kx == '0) && (r_ky == '0);
        w_out_valid = 1'b0;
        w_out_addr  = '0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_FETCH;
                    w_ox_nxt    = '0;
                    w_oy_nxt    = '0;
                    w_kx_nxt    = '0;
                    w_ky_nxt    = '0;
                end
            end

            S_FETCH: begin
                w_rd_en   = 1'b1;
                w_rd_addr = (r_oy + r_ky) * c_img_w + r_ox + r_kx;
                w_tap     = TAP_W'(r_ky) * c_k_tap + TAP_W'(r_kx);
                if (r_kx == c_km1) begin
                    w_kx_nxt = '0;
                    if (r_ky == c_km1) begin
                        // Last tap issued; its data is accumulated in DRAIN
                        w_ky_nxt    = '0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_ky_nxt = r_ky + 1'b1;
                    end
                end else begin
                    w_kx_nxt = r_kx + 1'b1;
                end
            end

            S_DRAIN: begin
                w_state_nxt = S_WRITE;
            end

            S_WRITE: begin
                w_out_valid = 1'b1;
                w_out_addr  = r_oy * c_out_w + r_ox;
                // out_ready_i only steers the transition, never an output
                if (bus.out_ready_i) begin
                    if ((r_ox == c_out_wm1) && (r_oy == c_out_hm1)) begin
                        w_ox_nxt    = '0;
                        w_oy_nxt    = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_FETCH;
                        if (r_ox == c_out_wm1) begin
                            w_ox_nxt = '0;
                            w_oy_nxt = r_oy + 1'b1;
                        end else begin
                            w_ox_nxt = r_ox + 1'b1;
                        end
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy_o          = (r_state != S_IDLE);
    assign done_o          = (r_state == S_DONE);
    assign bus.rd_en_o     = w_rd_en;
    assign bus.rd_addr_o   = w_rd_addr;
    assign bus.acc_en_o    = r_acc_en;
    assign bus.acc_clr_o   = r_acc_clr;
    assign bus.tap_o       = r_tap;
    assign bus.out_valid_o = w_out_valid;
    assign bus.out_addr_o  = w_out_addr;

endmodule

`default_nettype wire

// File: tb/tb_conv_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_conv_ctrl
// Description : Self-checking bench for conv_ctrl. Two instances run side by
//               side on shared stimulus: A with default parameters (8x8, K=3)
//               and B with a 2x2 map and K=1. A cycle-level reference model
//               derives every expected output from pixel index and the offset
//               within the current pixel's fetch window.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    always #5 clk = ~clk;

    conv_ctrl_if #(.ADDR_W(6), .TAP_W(4)) ifa ();
    conv_ctrl_if #(.ADDR_W(2), .TAP_W(1)) ifb ();

    logic busy_a, done_a, busy_b, done_b;

    conv_ctrl #(.IMG_W(8), .IMG_H(8), .K(3), .ADDR_W(6), .TAP_W(4)) dut_a (
        .clk_i(clk), .rst_n(rst_n), .start_i(start),
        .busy_o(busy_a), .done_o(done_a), .bus(ifa.master)
    );

    conv_ctrl #(.IMG_W(2), .IMG_H(2), .K(1), .ADDR_W(2), .TAP_W(1)) dut_b (
        .clk_i(clk), .rst_n(rst_n), .start_i(start),
        .busy_o(busy_b), .done_o(done_b), .bus(ifb.master)
    );

    typedef struct {
        logic [31:0] busy, rd_en, rd_addr, clr, en, tap, valid, oaddr, done;
    } obs_t;

    int cw[2] = '{8, 2};
    int ch[2] = '{8, 2};
    int ck[2] = '{3, 1};

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance
    int m_act[2], m_pix[2], m_fs[2], m_done[2];
    int gc = 0;
    int base = 0;
    int done_seen[2];
    int rd_log_a[0:511];
    int rd_log_b[0:63];

    task automatic check_val(input string tag, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, gc - base);
        end
    endtask

    function automatic obs_t get_obs(input int i);
        obs_t o;
        if (i == 0) begin
            o.busy = 32'(busy_a);            o.done  = 32'(done_a);
            o.rd_en = 32'(ifa.rd_en_o);      o.rd_addr = 32'(ifa.rd_addr_o);
            o.clr = 32'(ifa.acc_clr_o);      o.en = 32'(ifa.acc_en_o);
            o.tap = 32'(ifa.tap_o);          o.valid = 32'(ifa.out_valid_o);
            o.oaddr = 32'(ifa.out_addr_o);
        end else begin
            o.busy = 32'(busy_b);            o.done  = 32'(done_b);
            o.rd_en = 32'(ifb.rd_en_o);      o.rd_addr = 32'(ifb.rd_addr_o);
            o.clr = 32'(ifb.acc_clr_o);      o.en = 32'(ifb.acc_en_o);
            o.tap = 32'(ifb.tap_o);          o.valid = 32'(ifb.out_valid_o);
            o.oaddr = 32'(ifb.out_addr_o);
        end
        return o;
    endfunction

    // Input address of tap t for output pixel pix (raster order everywhere)
    function automatic int addr_of(input int i, input int pix, input int t);
        int ow, ox, oy, kx, ky;
        ow = cw[i] - ck[i] + 1;
        ox = pix % ow;  oy = pix / ow;
        kx = t % ck[i]; ky = t / ck[i];
        return (oy + ky) * cw[i] + ox + kx;
    endfunction

    task automatic model_check(input int i, input obs_t o);
        int kk, rel, ex_addr, ex_tap, ex_oa;
        bit rd, en, val, dn;
        string p;
        p   = (i == 0) ? "A" : "B";
        kk  = ck[i] * ck[i];
        rel = gc - m_fs[i];
        rd  = (m_act[i] != 0) && rel >= 0 && rel < kk;
        en  = (m_act[i] != 0) && rel >= 1 && rel <= kk;
        val = (m_act[i] != 0) && rel > kk;
        dn  = (gc == m_done[i]);
        ex_addr = rd  ? addr_of(i, m_pix[i], rel) : 0;
        ex_tap  = en  ? rel - 1 : 0;
        ex_oa   = val ? m_pix[i] : 0;
        check_val({p, ".busy"},     o.busy,    int'(m_act[i] != 0 || dn));
        check_val({p, ".done"},     o.done,    int'(dn));
        check_val({p, ".rd_en"},    o.rd_en,   int'(rd));
        check_val({p, ".rd_addr"},  o.rd_addr, ex_addr);
        check_val({p, ".acc_en"},   o.en,      int'(en));
        check_val({p, ".acc_clr"},  o.clr,     int'(en && rel == 1));
        check_val({p, ".tap"},      o.tap,     ex_tap);
        check_val({p, ".valid"},    o.valid,   int'(val));
        check_val({p, ".out_addr"}, o.oaddr,   ex_oa);
    endtask

    task automatic model_advance(input int i, input logic st, input logic rdy);
        int kk, rel, npix;
        kk   = ck[i] * ck[i];
        rel  = gc - m_fs[i];
        npix = (cw[i] - ck[i] + 1) * (ch[i] - ck[i] + 1);
        if (gc == m_done[i]) begin
            // completion cycle: start is ignored
        end else if (m_act[i] == 0) begin
            if (st) begin
                m_act[i] = 1; m_pix[i] = 0; m_fs[i] = gc + 1;
            end
        end else if (rel > kk && rdy) begin
            if (m_pix[i] == npix - 1) begin
                m_act[i] = 0; m_done[i] = gc + 1;
            end else begin
                m_pix[i]++; m_fs[i] = gc + 1;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_pix[i] = 0; m_fs[i] = 0; m_done[i] = -1;
        end
    endtask

    task automatic begin_scenario();
        base = gc;
        done_seen[0] = -1;
        done_seen[1] = -1;
        for (int j = 0; j < 512; j++) rd_log_a[j] = -1;
        for (int j = 0; j < 64; j++)  rd_log_b[j] = -1;
    endtask

    // One clock cycle: drive inputs, check both instances, advance the model
    task automatic tick(input logic st, input logic rdy);
        obs_t o;
        int rc;
        start = st;
        ifa.out_ready_i = rdy;
        ifb.out_ready_i = rdy;
        rc = gc - base;
        for (int i = 0; i < 2; i++) begin
            o = get_obs(i);
            model_check(i, o);
            if (o.done == 1 && done_seen[i] < 0) done_seen[i] = rc;
            if (i == 0 && rc < 512) rd_log_a[rc] = (o.rd_en == 1) ? int'(o.rd_addr) : -1;
            if (i == 1 && rc < 64)  rd_log_b[rc] = (o.rd_en == 1) ? int'(o.rd_addr) : -1;
        end
        if (rst_n) begin
            model_advance(0, st, rdy);
            model_advance(1, st, rdy);
        end
        @(posedge clk);
        #1;
        gc++;
    endtask

    // Defaults with out_ready_i high, start pulse at cycle 0
    task automatic run_basic();
        int first_rd[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        int last_rd[9]  = '{45, 46, 47, 53, 54, 55, 61, 62, 63};
        begin_scenario();
        tick(1'b1, 1'b1);
        repeat (405) tick(1'b0, 1'b1);
        for (int j = 0; j < 9; j++) begin
            check_val("A.first_pixel_read", rd_log_a[1 + j], first_rd[j]);
            check_val("A.last_pixel_read",  rd_log_a[386 + j], last_rd[j]);
        end
        for (int j = 0; j < 4; j++)
            check_val("B.read", rd_log_b[1 + 3 * j], j);
        check_val("A.done_cycle", done_seen[0], 397);
        check_val("B.done_cycle", done_seen[1], 13);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ifa.out_ready_i = 1'b0;
        ifb.out_ready_i = 1'b0;
        model_reset();
        begin_scenario();
        #1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b1);

        run_basic();

        // Backpressure: ready low for 5 cycles during pixel 0's WRITE
        begin_scenario();
        tick(1'b1, 1'b1);
        for (int c = 1; c < 410; c++) tick(1'b0, !(c >= 11 && c <= 15));
        check_val("A.done_cycle_bp", done_seen[0], 402);

        // Start pulses in FETCH, WRITE and DONE; then a genuine restart
        begin_scenario();
        tick(1'b1, 1'b1);
        for (int c = 1; c < 410; c++) tick(c == 5 || c == 11 || c == 397, 1'b1);
        check_val("A.done_cycle_noise", done_seen[0], 397);
        begin_scenario();
        tick(1'b1, 1'b1);
        repeat (12) tick(1'b0, 1'b1);
        check_val("A.restart_read", rd_log_a[1], 0);

        // Randomized start and backpressure
        begin_scenario();
        tick(1'b1, 1'b1);
        repeat (1500) tick(($urandom % 16) == 0, ($urandom % 4) != 0);
        repeat (600) tick(1'b0, 1'b1);

        // Reset mid-run at cycle 50, released at 53
        begin_scenario();
        tick(1'b1, 1'b1);
        while (gc - base < 50) tick(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        begin
            obs_t o;
            o = get_obs(0);
            check_val("rst.busy",    o.busy,    0);
            check_val("rst.rd_en",   o.rd_en,   0);
            check_val("rst.rd_addr", o.rd_addr, 0);
            check_val("rst.acc_en",  o.en,      0);
            check_val("rst.acc_clr", o.clr,     0);
            check_val("rst.tap",     o.tap,     0);
            check_val("rst.valid",   o.valid,   0);
            check_val("rst.out_addr", o.oaddr,  0);
            check_val("rst.done",    o.done,    0);
        end
        model_reset();
        repeat (3) tick(1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (420) tick(1'b0, 1'b1);
        check_val("rst.no_done", done_seen[0], -1);
        run_basic();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
